firx_decim_mac: RTL and testbench

FIRX_DECIM_MAC -- requirements
Module: firx_decim_mac

---
 rtl/firx_decim_mac.sv | 156 +++++++++++++++
 tb/tb_firx_decim_mac.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/firx_decim_mac.sv
// Decimating FIR filter: one tap multiply-accumulate per clock against an external registered coefficient ROM.
// Latency: y_avail rises NTAPS+4 cycles after the trigger sample's x_avail cycle.
// Backpressure: none. A trigger sample arriving while a computation is in flight is still stored, but the output is dropped and overrun pulses.
//
// Ports:
//   clock, reset        single clock; synchronous active-high reset
//   x_avail, x_in       input sample strobe and signed 24-bit sample
//   coef_addr           tap index to the ROM; bit 7 is always 0; held at 0 outside RUN
//   coef_data           signed Q1.17 coefficient, arriving one clock after coef_addr
//   y_avail, y_out      output strobe and saturated 24-bit result; y_out holds between strobes
//   overrun             one-cycle pulse when a trigger sample was not serviced
module firx_decim_mac #(
  parameter int NTAPS = 128,
  parameter int DECIM = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               x_avail,
  input  logic signed [23:0] x_in,
  output logic [7:0]         coef_addr,
  input  logic signed [17:0] coef_data,
  output logic               y_avail,
  output logic signed [23:0] y_out,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [6:0] LAST_TAP = 7'(NTAPS - 1);
  localparam logic [6:0] DEC_LAST = 7'(DECIM - 1);

  // Sample history. It is deliberately not reset, so it has no reset branch.
  logic signed [23:0] mem [256];

  state_t             state_q;
  logic [7:0]         wptr_q;
  logic [7:0]         snap_q;
  logic [6:0]         dcnt_q;
  logic [7:0]         coef_addr_q;   // doubles as the tap index k while in RUN
  logic               y_avail_q;
  logic signed [23:0] y_out_q;
  logic               overrun_q;

  logic               trig;
  logic [7:0]         rd_addr;
  logic signed [23:0] rd_q;
  logic               s1_vld_q, s1_first_q, s1_last_q;
  logic signed [41:0] prod_q;
  logic               s2_vld_q, s2_first_q, s2_last_q;
  logic signed [48:0] acc_q;
  logic               acc_last_q;
  logic signed [23:0] y_sat;

  assign trig    = x_avail && (dcnt_q == DEC_LAST);
  // Walk backwards from the newest sample. 8-bit wrap gives the modulo-256 ring.
  assign rd_addr = snap_q - coef_addr_q;

  assign coef_addr = coef_addr_q;
  assign y_avail   = y_avail_q;
  assign y_out     = y_out_q;
  assign overrun   = overrun_q;

  always_ff @(posedge clock) begin
    if (x_avail && !reset) mem[wptr_q] <= x_in;
  end

  // Registered buffer read. It lines up with coef_data from the registered ROM.
  always_ff @(posedge clock) begin
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      dcnt_q <= '0;
    end else if (x_avail) begin
      wptr_q <= wptr_q + 8'd1;
      dcnt_q <= (dcnt_q == DEC_LAST) ? 7'd0 : dcnt_q + 7'd1;
    end
  end

  // Keep acc[40:17] only when bits 48..40 agree. Otherwise clamp to full scale.
  always_comb begin
    y_sat = acc_q[40:17];
    if (!((&acc_q[48:40]) || !(|acc_q[48:40])))
      y_sat = acc_q[48] ? 24'sh800000 : 24'sh7FFFFF;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      coef_addr_q <= '0;
      y_avail_q   <= 1'b0;
      y_out_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      y_avail_q <= 1'b0;
      overrun_q <= trig && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_q     <= RUN;
            snap_q      <= wptr_q;
            coef_addr_q <= '0;
          end
        end
        RUN: begin
          if (coef_addr_q[6:0] == LAST_TAP) begin
            state_q     <= DRAIN;
            coef_addr_q <= '0;
          end else begin
            coef_addr_q <= coef_addr_q + 8'd1;
          end
        end
        DRAIN: begin
          if (acc_last_q) begin
            state_q   <= DONE;
            y_avail_q <= 1'b1;
            y_out_q   <= y_sat;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // MAC pipeline: read/coef (s1) -> product (s2) -> accumulate. First/last tags ride along.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      acc_last_q <= 1'b0;
    end else begin
      s1_vld_q   <= (state_q == RUN);
      s1_first_q <= (state_q == RUN) && (coef_addr_q == 8'd0);
      s1_last_q  <= (state_q == RUN) && (coef_addr_q[6:0] == LAST_TAP);
      s2_vld_q   <= s1_vld_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      prod_q     <= rd_q * coef_data;
      if (s2_vld_q)
        acc_q <= s2_first_q ? {{7{prod_q[41]}}, prod_q}
                            : acc_q + {{7{prod_q[41]}}, prod_q};
      acc_last_q <= s2_vld_q && s2_last_q;
    end
  end

endmodule

// File: tb/tb_firx_decim_mac.sv
// Bench for firx_decim_mac: directed vectors, a cycle-level reference model, and hand-computed literal checks.
// The model works from sample history and trigger timing (output due LAT cycles after an accepted trigger).
// The monitor compares every cycle. Literal checks cover DC, impulse, saturation, overrun and reset.
module tb_firx_decim_mac;
  localparam int NTAPS = 128;
  localparam int DECIM = 8;
  localparam int LAT   = NTAPS + 4;

  logic               clock   = 1'b0;
  logic               reset   = 1'b1;
  logic               x_avail = 1'b0;
  logic signed [23:0] x_in    = '0;
  logic [7:0]         coef_addr;
  logic signed [17:0] coef_data;
  logic               y_avail;
  logic signed [23:0] y_out;
  logic               overrun;

  always #5 clock = ~clock;

  firx_decim_mac #(.NTAPS(NTAPS), .DECIM(DECIM)) u_dut (
    .clock(clock), .reset(reset), .x_avail(x_avail), .x_in(x_in),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .y_avail(y_avail), .y_out(y_out), .overrun(overrun)
  );

  // External registered coefficient ROM.
  logic signed [17:0] coef_rom [NTAPS];
  always @(posedge clock) coef_data <= coef_rom[coef_addr[6:0]];

  typedef struct {int cyc; bit known; logic signed [23:0] y;} exp_t;

  int                 n_cmp = 0;
  int                 n_fail = 0;
  int                 cyc = 0;
  exp_t               eq[$];
  exp_t               cur_e;
  logic signed [23:0] mmem [256];
  bit                 mvalid [256];
  int                 mwp = 0, mcnt = 0, busy_until = -1, ovr_cyc = -1, run_start = -1000, wa = 0;
  bit                 hold_known = 1'b1;
  logic signed [23:0] hold_y = '0;
  bit                 exp_yav;
  int                 exp_ca;
  int                 n_yav = 0, n_ovr = 0;
  logic signed [23:0] ylog[$];

  task automatic chk(input string nm, input longint act, input longint want);
    n_cmp++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, want);
    end
  endtask

  // Result of an accepted trigger whose newest sample sits at ring address a.
  function automatic exp_t predict(input int a);
    exp_t   r;
    longint acc = 0;
    longint lim = longint'(1) << 40;
    r.known = 1'b1;
    r.cyc   = 0;
    for (int k = 0; k < NTAPS; k++) begin
      int idx = (a - k + 256) % 256;
      if (!mvalid[idx]) r.known = 1'b0;
      acc += longint'(coef_rom[k]) * longint'(mmem[idx]);
    end
    if (acc >= lim)       r.y = 24'sh7FFFFF;
    else if (acc < -lim)  r.y = 24'sh800000;
    else                  r.y = 24'(acc >>> 17);
    return r;
  endfunction

  // Drive one sample, then idle so that samples are gap cycles apart.
  task automatic send(input logic signed [23:0] v, input int gap);
    x_in = v; x_avail = 1'b1;
    @(posedge clock); #1;
    x_avail = 1'b0;
    for (int i = 1; i < gap; i++) begin @(posedge clock); #1; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
  endtask

  int   b_y, b_o, b_log, t_trig, lat;
  bit   found;

  initial begin
    for (int k = 0; k < NTAPS; k++) coef_rom[k] = 18'sd1024;
    fork
      // Reference model (sampled at posedge) and per-cycle compare (sampled at negedge).
      forever begin
        @(posedge clock);
        if (reset) begin
          mwp = 0; mcnt = 0; busy_until = -1; ovr_cyc = -1; run_start = -1000;
          eq.delete(); hold_known = 1'b1; hold_y = '0;
        end else if (x_avail) begin
          wa = mwp;
          mmem[wa] = x_in; mvalid[wa] = 1'b1;
          mwp  = (mwp + 1) % 256;
          mcnt = (mcnt + 1) % DECIM;
          if (mcnt == 0) begin
            if (cyc > busy_until) begin
              cur_e = predict(wa);
              cur_e.cyc = cyc + LAT;
              eq.push_back(cur_e);
              busy_until = cyc + LAT;
              run_start  = cyc;
            end else begin
              ovr_cyc = cyc + 1;
            end
          end
        end
        cyc++;
        @(negedge clock);
        exp_yav = (eq.size() > 0) && (eq[0].cyc == cyc);
        if (exp_yav) begin
          cur_e = eq.pop_front();
          hold_known = cur_e.known;
          hold_y = cur_e.y;
        end
        chk("y_avail", longint'(y_avail), longint'(exp_yav));
        chk("overrun", longint'(overrun), longint'(ovr_cyc == cyc));
        exp_ca = (cyc > run_start && cyc <= run_start + NTAPS) ? cyc - run_start - 1 : 0;
        chk("coef_addr", longint'(coef_addr), longint'(exp_ca));
        if (hold_known) chk("y_out", longint'(y_out), longint'(hold_y));
        if (y_avail) begin n_yav++; ylog.push_back(y_out); end
        if (overrun) n_ovr++;
      end

      begin
        // Reset values.
        repeat (3) @(posedge clock);
        #1; reset = 1'b0;
        @(posedge clock); #1;
        chk("rst_y_out", longint'(y_out), 0);
        chk("rst_coef_addr", longint'(coef_addr), 0);
        chk("rst_y_avail", longint'(y_avail), 0);
        chk("rst_overrun", longint'(overrun), 0);

        // DC: coefficients sum to 128*1024 = 2^17, so the output equals the input.
        b_y = n_yav;
        for (int i = 0; i < 256; i++) send(24'sd1000, 200);
        idle(200);
        chk("dc_pulses", longint'(n_yav - b_y), 32);
        chk("dc_y", longint'(y_out), 1000);

        // Impulse: coef[k] = k+1 and 131072 = 2^17, so output k after the impulse is k+1.
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = 18'(k + 1);
        for (int i = 0; i < 128; i++) send(24'sd0, 20);
        idle(200);
        b_log = ylog.size();
        send(24'sd131072, 20);
        for (int i = 0; i < 143; i++) send(24'sd0, 20);
        idle(200);
        chk("imp_pulses", longint'(ylog.size() - b_log), 18);
        for (int i = 0; i < 18; i++)
          chk("imp_y", (b_log + i < ylog.size()) ? longint'(ylog[b_log + i]) : -64'sd1,
              (i < 16) ? longint'((i + 1) * 8) : 64'sd0);

        // Saturation at both rails.
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = 18'sd131071;
        for (int i = 0; i < 128; i++) send(24'sh7FFFFF, 17);
        idle(200);
        chk("sat_pos", longint'(y_out), 8388607);
        for (int i = 0; i < 128; i++) send(24'sh800000, 17);
        idle(200);
        chk("sat_neg", longint'(y_out), -8388608);

        // Overrun: triggers every 88 cycles, so every other trigger lands while busy.
        // Each y_avail also coincides with a new sample.
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = 18'(1000 - 13 * k);
        b_y = n_yav; b_o = n_ovr;
        for (int i = 0; i < 64; i++) send(24'((i * 7919) % 20000 - 10000), 11);
        idle(200);
        chk("ovr_pulses", longint'(n_ovr - b_o), 4);
        chk("ovr_y_pulses", longint'(n_yav - b_y), 4);

        // Reset while tap 60 is in progress.
        for (int i = 0; i < 7; i++) send(24'(500 + i), 3);
        send(-24'sd777, 1);
        idle(60);
        chk("rst_tap", longint'(coef_addr), 60);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        b_y = n_yav;
        idle(200);
        chk("rst_no_y", longint'(n_yav - b_y), 0);
        chk("rst_y_held0", longint'(y_out), 0);
        chk("rst_ca0", longint'(coef_addr), 0);

        // After reset, the 8th new sample triggers. Measure latency to y_avail.
        for (int i = 0; i < 7; i++) send(24'(-2000 + i * 300), 3);
        x_in = 24'sd4321; x_avail = 1'b1; t_trig = cyc;
        @(posedge clock); #1;
        x_avail = 1'b0;
        found = 1'b0; lat = -1;
        for (int i = 0; i < 300 && !found; i++) begin
          @(negedge clock);
          if (y_avail) begin found = 1'b1; lat = cyc - t_trig; end
        end
        chk("latency", longint'(lat), longint'(LAT));
        idle(5);
        chk("rst_next_y", longint'(n_yav - b_y), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    join
  end

endmodule
